serial_read_buffer: RTL and testbench
=====================================

SERIAL_READ_BUFFER -- requirements
Module: serial_read_buffer

Interface
REQ-001 Parameter BUF_SIZE, default 8, SHALL set the maximum number of bits captured per transfer.
REQ-002 Derived constant CTR_SIZE SHALL equal $clog2(BUF_SIZE+1).
REQ-003 sys_clk  input  1  system clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  single-cycle pulse that begins a transfer.
REQ-006 read_sig  input  1  single-cycle sample strobe, synchronous to sys_clk.
REQ-007 data_in  input  1  serial input line.
REQ-008 read_count  input  CTR_SIZE  number of bits to capture; sampled only on an accepted start.
REQ-009 data_out  output  BUF_SIZE  captured word, MSB-aligned.
REQ-010 done_sig  output  1  high when idle with a valid result; low while busy.

Function
REQ-011 The state machine SHALL have states IDLE, READ and RESET; an unused encoding SHALL drive done_sig low and go to RESET.
REQ-012 In IDLE, start=1 SHALL: drive done_sig low, load counter = min(read_count, BUF_SIZE), clear the internal shift register, and go to READ.
REQ-013 read_count=0 on start SHALL skip READ: next cycle data_out=0, done_sig=1, stay in IDLE.
REQ-014 In IDLE, read_sig SHALL be ignored, including when it coincides with start.
REQ-015 In READ, each read_sig=1 cycle SHALL shift data_in into the LSB of the shift register and decrement the counter.
REQ-016 Bit order SHALL be MSB-first: the first sampled bit SHALL end at data_out[BUF_SIZE-1], the k-th at data_out[BUF_SIZE-k].
REQ-017 On the read_sig that samples the last bit, the next edge SHALL load data_out with the MSB-aligned result (unused low bits 0), set done_sig=1 and return to IDLE.
REQ-018 Latency: done_sig SHALL rise on the edge that samples the final bit (one cycle after the strobe is presented).
REQ-019 data_out SHALL hold the previous result unchanged throughout READ and change only at completion, reset, or the REQ-013 case.
REQ-020 start asserted in READ SHALL be ignored; the transfer in progress SHALL continue.
REQ-021 Cycles without read_sig in READ SHALL hold all state; there SHALL be no timeout.
REQ-022 read_count > BUF_SIZE SHALL be clamped to BUF_SIZE.

Reset
REQ-023 rst=1 SHALL override every other input: done_sig=0, state=RESET on the next edge.
REQ-024 RESET SHALL clear data_out, the shift register and the counter, set done_sig=1 and go to IDLE, one cycle later.
REQ-025 Power-up state SHALL be RESET with done_sig=0.
REQ-026 rst during READ SHALL abort the transfer; no partial result SHALL appear on data_out.

Verification
REQ-027 BUF_SIZE=8, read_count=8: start, then serial bits 1,0,1,1,0,0,1,0 on 8 strobes -> data_out=8'hB2, done_sig=1 the cycle after strobe 8.
REQ-028 read_count=3: start, then bits 1,1,0 -> data_out=8'hC0, done_sig=1; further read_sig pulses leave data_out=8'hC0.
REQ-029 read_count=0: start -> next cycle data_out=0, done_sig=1, no strobes consumed.
REQ-030 read_count=8: rst after 4 strobes -> done_sig=0, then 1 a cycle later, data_out=0; a new 8-bit read 8'h5A then completes correctly.
REQ-031 Start coincident with read_sig, followed by start pulses mid-transfer and gaps of 0-5 idle cycles between strobes -> the coincident strobe is not sampled and the result equals the expected word.
REQ-032 read_count=15 with BUF_SIZE=8 -> exactly 8 strobes consumed, done_sig=1 after strobe 8.

Source files
------------

// File: rtl/serial_read_buffer.sv
// Serial-to-parallel capture buffer: samples data_in on each read_sig strobe,
// MSB-first, and presents the MSB-aligned word on data_out when the transfer ends.
module serial_read_buffer #(
  parameter  int BUF_SIZE = 8,
  localparam int CTR_SIZE = $clog2(BUF_SIZE + 1)
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic                start,
  input  logic                read_sig,
  input  logic                data_in,
  input  logic [CTR_SIZE-1:0] read_count,
  output logic [BUF_SIZE-1:0] data_out,
  output logic                done_sig
);

  // S_RESET is the all-zero encoding so zero-initialised flops power up in RESET.
  typedef enum logic [1:0] {
    S_RESET = 2'b00,
    S_IDLE  = 2'b01,
    S_READ  = 2'b10
  } state_t;

  localparam logic [CTR_SIZE-1:0] BUF_BITS = CTR_SIZE'(BUF_SIZE);

  state_t              state_q, state_d;
  logic [BUF_SIZE-1:0] shift_q, shift_d;
  logic [BUF_SIZE-1:0] data_q,  data_d;
  logic [CTR_SIZE-1:0] cnt_q,   cnt_d;
  logic [CTR_SIZE-1:0] len_q,   len_d;
  logic                done_q,  done_d;

  logic [CTR_SIZE-1:0] count_clamped;
  logic [BUF_SIZE-1:0] shift_in;

  assign count_clamped = (read_count > BUF_BITS) ? BUF_BITS : read_count;
  assign shift_in      = (shift_q << 1) | BUF_SIZE'(data_in);

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    done_d  = done_q;

    if (rst) begin
      state_d = S_RESET;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        S_RESET: begin
          shift_d = '0;
          data_d  = '0;
          cnt_d   = '0;
          len_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        S_IDLE: begin
          if (start) begin
            shift_d = '0;
            cnt_d   = count_clamped;
            len_d   = count_clamped;
            if (count_clamped == '0) begin
              data_d = '0;
              done_d = 1'b1;
            end else begin
              done_d  = 1'b0;
              state_d = S_READ;
            end
          end
        end
        S_READ: begin
          if (read_sig) begin
            shift_d = shift_in;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == CTR_SIZE'(1)) begin
              // Low-aligned capture moved up so the first bit lands in the MSB.
              data_d  = shift_in << (BUF_BITS - len_q);
              done_d  = 1'b1;
              state_d = S_IDLE;
            end
          end
        end
        default: begin
          done_d  = 1'b0;
          state_d = S_RESET;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the synchronous reset
  // is folded into the next-state logic above, so this block has no reset branch.
  always_ff @(posedge sys_clk) begin
    state_q <= state_d;
    shift_q <= shift_d;
    data_q  <= data_d;
    cnt_q   <= cnt_d;
    len_q   <= len_d;
    done_q  <= done_d;
  end

  assign data_out = data_q;
  assign done_sig = done_q;

endmodule

// File: tb/tb_serial_read_buffer.sv
// Directed bench for serial_read_buffer (BUF_SIZE=8) with hand-computed expected words.
module tb_serial_read_buffer;

  localparam int BUF_SIZE = 8;
  localparam int CTR_SIZE = $clog2(BUF_SIZE + 1);

  logic                sys_clk = 1'b0;
  logic                rst;
  logic                start;
  logic                read_sig;
  logic                data_in;
  logic [CTR_SIZE-1:0] read_count;
  logic [BUF_SIZE-1:0] data_out;
  logic                done_sig;

  int n_cmp = 0;
  int n_bad = 0;

  serial_read_buffer #(.BUF_SIZE(BUF_SIZE)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .start      (start),
    .read_sig   (read_sig),
    .data_in    (data_in),
    .read_count (read_count),
    .data_out   (data_out),
    .done_sig   (done_sig)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic strobe(input logic bit_v);
    read_sig = 1'b1;
    data_in  = bit_v;
    step();
    read_sig = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic begin_xfer(input logic [CTR_SIZE-1:0] cnt);
    start      = 1'b1;
    read_count = cnt;
    step();
    start      = 1'b0;
  endtask

  initial begin
    logic [7:0] word;

    rst = 1'b1; start = 1'b0; read_sig = 1'b0; data_in = 1'b0; read_count = '0;
    step();
    check("rst_done_low", 32'(done_sig), 32'd0);
    rst = 1'b0;
    step();
    check("reset_done_high", 32'(done_sig), 32'd1);
    check("reset_data_zero", 32'(data_out), 32'h00);

    // Full 8-bit read: 1,0,1,1,0,0,1,0 -> B2
    begin_xfer(4'd8);
    check("busy_after_start", 32'(done_sig), 32'd0);
    word = 8'hB2;
    for (int i = 7; i >= 1; i--) strobe(word[i]);
    check("b2_not_done_at_7", 32'(done_sig), 32'd0);
    check("b2_data_held", 32'(data_out), 32'h00);
    strobe(word[0]);
    check("b2_done", 32'(done_sig), 32'd1);
    check("b2_data", 32'(data_out), 32'hB2);

    // 3-bit read: 1,1,0 -> C0, previous result held while busy
    begin_xfer(4'd3);
    strobe(1'b1);
    check("c0_hold_prev", 32'(data_out), 32'hB2);
    strobe(1'b1);
    strobe(1'b0);
    check("c0_done", 32'(done_sig), 32'd1);
    check("c0_data", 32'(data_out), 32'hC0);
    strobe(1'b1);
    strobe(1'b1);
    check("c0_idle_strobes", 32'(data_out), 32'hC0);
    check("c0_idle_done", 32'(done_sig), 32'd1);

    // Reset mid-transfer: no partial result, then a clean 5A read
    begin_xfer(4'd8);
    strobe(1'b1); strobe(1'b0); strobe(1'b1); strobe(1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_done_low", 32'(done_sig), 32'd0);
    check("abort_data_held", 32'(data_out), 32'hC0);
    step();
    check("abort_done_high", 32'(done_sig), 32'd1);
    check("abort_data_zero", 32'(data_out), 32'h00);
    begin_xfer(4'd8);
    word = 8'h5A;
    for (int i = 7; i >= 0; i--) strobe(word[i]);
    check("5a_done", 32'(done_sig), 32'd1);
    check("5a_data", 32'(data_out), 32'h5A);

    // Zero-length transfer
    begin_xfer(4'd0);
    check("zero_done", 32'(done_sig), 32'd1);
    check("zero_data", 32'(data_out), 32'h00);
    strobe(1'b1);
    check("zero_no_consume", 32'(data_out), 32'h00);

    // Start coincident with a strobe, restarts and gaps mid-transfer -> 3C
    read_sig = 1'b1; data_in = 1'b1;
    begin_xfer(4'd8);
    read_sig = 1'b0; data_in = 1'b0;
    word = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      for (int g = 0; g < (7 - i) % 6; g++) begin
        start = (g == 0); read_count = 4'd3;
        step();
        start = 1'b0;
      end
      strobe(word[i]);
      if (i == 4) check("gap_busy", 32'(done_sig), 32'd0);
      if (i == 4) check("gap_data_held", 32'(data_out), 32'h00);
    end
    check("gap_done", 32'(done_sig), 32'd1);
    check("gap_data", 32'(data_out), 32'h3C);

    // read_count=15 clamps to 8 strobes -> A5
    begin_xfer(4'd15);
    word = 8'hA5;
    for (int i = 7; i >= 1; i--) strobe(word[i]);
    check("clamp_not_done_at_7", 32'(done_sig), 32'd0);
    strobe(word[0]);
    check("clamp_done", 32'(done_sig), 32'd1);
    check("clamp_data", 32'(data_out), 32'hA5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
